// File: rtl/dnnweaver_fxp_pkg.sv
// Shared fixed-point helpers for the DnnWeaver datapath.
// Provides saturation bounds, the round-half-up shift and default widths.
package dnnweaver_fxp_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF = 16;

    typedef struct packed {
        logic signed [63:0] max;
        logic signed [63:0] min;
    } sat_bounds_t;

    function automatic sat_bounds_t sat_bounds(input int width);
        sat_bounds_t b;
        b.max = (64'sd1 <<< (width - 1)) - 64'sd1;
        b.min = -(64'sd1 <<< (width - 1));
        return b;
    endfunction

    // The add runs at 64 bits, so the rounding term never wraps (ACC_WIDTH <= 62).
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int s, input int acc_w);
        if (s >= acc_w) return v[63] ? -64'sd1 : 64'sd0;
        if (s == 0) return v;
        return (v + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

endpackage

// File: rtl/fxp_round_shift_sat.sv
// Combinational requantizer: round-half-up right shift, then clip to OUT_WIDTH.
module fxp_round_shift_sat
    import dnnweaver_fxp_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH-1:0]   acc_val,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   out_val,
    output logic                   sat
);

    localparam sat_bounds_t        BND   = sat_bounds(OUT_WIDTH);
    localparam logic signed [63:0] MAX_V = BND.max;
    localparam logic signed [63:0] MIN_V = BND.min;

    logic signed [63:0] shifted;

    always_comb begin
        shifted = round_shift(64'(signed'(acc_val)), 32'(shift), ACC_WIDTH);
        out_val = shifted[OUT_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            out_val = MAX_V[OUT_WIDTH-1:0];
            sat     = 1'b1;
        end else if (shifted < MIN_V) begin
            out_val = MIN_V[OUT_WIDTH-1:0];
            sat     = 1'b1;
        end
    end

endmodule

// File: rtl/signed_adder.sv
// Fixed-point signed adder with optional output register.
// Both operands are sign-extended to OUT_WIDTH; the sum wraps.
module signed_adder #(
    parameter string DTYPE           = "FXP",
    parameter string REGISTER_OUTPUT = "FALSE",
    parameter int    IN1_WIDTH       = 20,
    parameter int    IN2_WIDTH       = 32,
    parameter int    OUT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [IN1_WIDTH-1:0] a,
    input  logic [IN2_WIDTH-1:0] b,
    output logic [OUT_WIDTH-1:0] out
);

    logic [OUT_WIDTH-1:0] sum;
    logic [OUT_WIDTH-1:0] sum_q;

    always_comb begin
        sum = '0;
        if (DTYPE == "FXP")
            sum = OUT_WIDTH'(signed'(a)) + OUT_WIDTH'(signed'(b));
    end

    always_ff @(posedge clk) begin
        if (reset)
            sum_q <= '0;
        else if (enable)
            sum_q <= sum;
    end

    assign out = (REGISTER_OUTPUT == "TRUE") ? sum_q : sum;

endmodule

// File: rtl/accumulator_requant_stage.sv
// Accumulates groups of signed beats and emits one requantized, saturated
// result per group through a single-entry output register.
module accumulator_requant_stage
    import dnnweaver_fxp_pkg::*;
#(
    parameter int IN_WIDTH    = 20,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_last,
    input  logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat
);

    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [ACC_WIDTH-1:0]   new_sum;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [SHIFT_WIDTH-1:0] eff_shift;
    logic                   first;
    logic                   accept;
    logic [OUT_WIDTH-1:0]   rq_data;
    logic                   rq_sat;

    // Stall only while a finished result sits unaccepted.
    assign in_ready  = !reset && !(out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign new_sum   = first ? ACC_WIDTH'(signed'(in_data)) : acc_sum;
    assign eff_shift = first ? shift_amt : shift_q;

    signed_adder #(
        .DTYPE          ("FXP"),
        .REGISTER_OUTPUT("FALSE"),
        .IN1_WIDTH      (IN_WIDTH),
        .IN2_WIDTH      (ACC_WIDTH),
        .OUT_WIDTH      (ACC_WIDTH)
    ) u_add (
        .clk   (clk),
        .reset (reset),
        .enable(1'b1),
        .a     (in_data),
        .b     (acc),
        .out   (acc_sum)
    );

    fxp_round_shift_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_rq (
        .acc_val(new_sum),
        .shift  (eff_shift),
        .out_val(rq_data),
        .sat    (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            shift_q   <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= new_sum;
                first <= in_last;
                if (first)
                    shift_q <= shift_amt;
            end
            // A new result takes priority over retiring the old one.
            if (accept && in_last) begin
                out_valid <= 1'b1;
                out_data  <= rq_data;
                out_sat   <= rq_sat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/accumulator_requant_stage.md
# accumulator_requant_stage

Streaming accumulate-and-requantize stage placed directly downstream of the fixed-point `signed_adder`. It feeds the adder's result back as the running sum. For each group of signed inputs it emits one rounded, right-shifted, saturated result. Input and output use valid/ready handshakes. It sits between the PE-array partial-sum output and the output buffer write port.

## Interface
Parameters:
- `IN_WIDTH`, 20: signed input sample width.
- `ACC_WIDTH`, 32: accumulator width, with `ACC_WIDTH >= IN_WIDTH`.
- `OUT_WIDTH`, 16: signed output width, with `OUT_WIDTH <= ACC_WIDTH`.
- `SHIFT_WIDTH`, 5: width of the requantize shift amount.

Ports:
- `clk`, input, 1: the only clock.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: stage can accept a beat.
- `in_data`, input, `IN_WIDTH`: signed sample.
- `in_last`, input, 1: the beat is the final beat of its group.
- `shift_amt`, input, `SHIFT_WIDTH`: right-shift amount, sampled on the first beat of each group.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, `OUT_WIDTH`: requantized signed result.
- `out_sat`, output, 1: the result was clipped to the `OUT_WIDTH` range.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- `in_ready = !(out_valid && !out_ready)`.
  - This is a combinational path from `out_ready`.
  - The stage stalls only while a completed result is held unaccepted.
- Group state uses a 1-bit `first` flag, which is set by reset and set after every accepted `in_last` beat.
- First beat of a group:
  - `acc <= sext(in_data)`. The previous sum is never added in.
  - `shift_q <= shift_amt`.
  - `first <= in_last`.
- Subsequent beats: `acc <= acc + sext(in_data)`.
  - The add uses a `signed_adder` instance with DTYPE "FXP" and REGISTER_OUTPUT "FALSE".
  - Its `a` input is `in_data` and its `b` input is `acc`.
  - The sum wraps modulo 2^`ACC_WIDTH`. The accumulator does not saturate.
- Beat that has `in_last` set:
  - The new sum is `S`, the first-beat value or `acc + in_data`.
  - `S` is requantized and registered into `out_data` and `out_sat`.
  - `out_valid <= 1`.
- Requantize, with `s` equal to the shift in effect:
  - If `s > 0`, add `1 << (s-1)` (round half up), then arithmetic-shift right by `s`.
  - The rounding add is done at `ACC_WIDTH+1` bits so it cannot wrap.
  - Saturate to `[-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]`.
  - `out_sat = 1` if the result was clipped.
  - If `s >= ACC_WIDTH`, the shift result is the sign fill (0 or -1).
- A single-beat group (`in_last` on the first beat) outputs the requantized `in_data` using that beat's `shift_amt`.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a new `in_last` beat is accepted in the same cycle.
  - In that case the new result is loaded, giving back-to-back results at full rate.
  - `out_data` and `out_sat` stay stable while `out_valid && !out_ready`.
- Beats of the next group may be accepted while a result is pending and `out_ready` is high. Accumulation is independent of the output register.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sat=0`, `acc=0`, `shift_q=0`, `first=1`.
  - `in_ready` is therefore 1 immediately after reset.
- Latency: an `in_last` beat accepted in cycle t gives `out_valid=1` in cycle t+1.
- Throughput is one input beat per cycle. A stream of single-beat groups gives one result per cycle when `out_ready` is held at 1.
- Reset asserted mid-group or with a pending result:
  - The partial group and the pending result are discarded.
  - The next cycle is in reset state.
  - Input beats presented during reset are not accepted: `in_ready` is forced to 0 while `reset` is high.
- `in_valid` with `in_ready=0`: the beat is not consumed and upstream holds it (standard valid/ready rule).
- `in_valid=0` between beats of a group: `acc` holds and the group continues on the next accepted beat.

## Structure
- Shared package `dnnweaver_fxp_pkg` holds:
  - the saturation-bound constants function (max/min for a given width);
  - the round-shift helper;
  - `localparam` defaults for `ACC_WIDTH` and `OUT_WIDTH`.
- Sub-module `fxp_round_shift_sat` is purely combinational.
  - Inputs: `ACC_WIDTH` value and shift.
  - Outputs: `OUT_WIDTH` value and sat flag.
  - It is instantiated once, ahead of the output register.
- `signed_adder` is instantiated for the accumulate add. Control logic (`first` flag, handshake, output register) lives in the top.

## Test plan
- Group {5, -3, 10, last 7}, shift 0, `out_ready=1` -> `out_data=19`, `out_sat=0`, one cycle after the last beat.
- Group {6}, shift 2 -> (6+2)>>2 = 2. Group {-6}, shift 2 -> (-6+2)>>2 = -1. Both with `out_sat=0`.
- Group {300000, 300000}, shift 0, `OUT_WIDTH=16` -> `out_data=32767`, `out_sat=1`. Group {-300000} -> `-32768`, `out_sat=1`.
- Hold `out_ready=0` for 5 cycles after a result, while the next group is pending -> `in_ready=0`, output stable; release -> the result is consumed and the next group proceeds, with no beats lost.
- Back-to-back single-beat groups {1}, {2}, {3}, `out_ready=1` -> outputs 1, 2, 3 on consecutive cycles.
- Assert `reset` after 2 beats of a group {4, 4, ...} -> `out_valid` stays 0; new group {9} after reset -> `out_data=9`, with no residue from the old group.
